wb_mul_arb: RTL

//   Round-robin arbiter and sequencer that time-shares one wb_mul multiplier among

---
 rtl/wb_mul_arb.sv | 119 +++++++++++
 1 files changed

// File: rtl/wb_mul_arb.sv
// Round-robin arbiter that time-shares one multiplier among NREQ gain requesters.
// Requester IDs ride a tag pipeline that mirrors the multiplier latency.
module wb_mul_arb #(
    parameter int NREQ    = 3,
    parameter int IDW     = 2,
    parameter int ASIZE   = 32,
    parameter int BSIZE   = 16,
    parameter int PSIZE   = 66,
    parameter int MUL_LAT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    output logic                  idle,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*ASIZE-1:0] req_a,
    input  logic [NREQ*BSIZE-1:0] req_b,
    output logic                  mul_ce,
    output logic [ASIZE-1:0]      mul_a,
    output logic [BSIZE-1:0]      mul_b,
    output logic                  mul_reload,
    input  logic [PSIZE-1:0]      mul_p,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [PSIZE-1:0]      rsp_p
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDW-1:0]     rr_ptr;
    logic [MUL_LAT-1:0] tag_v;
    logic [IDW-1:0]     tag_id [MUL_LAT];
    logic [MUL_LAT-1:0] tag_v_nxt;
    logic               granted;
    logic [IDW-1:0]     grant_id;
    logic               inflight_nxt;

    assign rsp_valid  = tag_v[MUL_LAT-1];
    assign rsp_id     = tag_id[MUL_LAT-1];
    assign rsp_p      = mul_p;
    assign mul_ce     = ~(rsp_valid & ~rsp_ready);
    assign mul_reload = 1'b1;
    assign idle       = (state == IDLE);

    always_comb begin
        int idx;
        idx      = 0;
        granted  = 1'b0;
        grant_id = '0;
        if (state == RUN && mul_ce) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= NREQ) idx = idx - NREQ;
                if (!granted && req_valid[idx]) begin
                    granted  = 1'b1;
                    grant_id = IDW'(idx);
                end
            end
        end
    end

    assign req_ready = granted ? (NREQ'(1) << grant_id) : '0;
    assign mul_a     = granted ? req_a[grant_id*ASIZE +: ASIZE] : '0;
    assign mul_b     = granted ? req_b[grant_id*BSIZE +: BSIZE] : '0;

    // Occupancy after this edge, so DRAIN->IDLE lands right after the last accept.
    assign tag_v_nxt    = {tag_v[MUL_LAT-2:0], granted};
    assign inflight_nxt = mul_ce ? |tag_v_nxt : |tag_v;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (granted) begin
            rr_ptr <= (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_v <= '0;
            for (int k = 0; k < MUL_LAT; k++) tag_id[k] <= '0;
        end else if (mul_ce) begin
            tag_v     <= tag_v_nxt;
            tag_id[0] <= grant_id;
            for (int k = 1; k < MUL_LAT; k++) tag_id[k] <= tag_id[k-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (en) state_nxt = RUN;
            end
            RUN: begin
                if (!en) state_nxt = inflight_nxt ? DRAIN : IDLE;
            end
            DRAIN: begin
                if (en)                 state_nxt = RUN;
                else if (!inflight_nxt) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
